// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - CSR op encodings, CSR addresses and address decode helper.
package csr_access_unit_pkg;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_t;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;

  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CSR_MVENDORID) || (addr == CSR_MARCHID) ||
           (addr == CSR_MSTATUS)   || (addr == CSR_MIE)     ||
           (addr == CSR_MTVEC);
  endfunction

endpackage

// File: rtl/csr_wdata_gen.sv
// rtl/csr_wdata_gen.sv - new CSR value and write-enable for a read-modify-write op.
import csr_access_unit_pkg::*;

module csr_wdata_gen (
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_val,
  input  logic [4:0]  i_rs1_idx,
  input  logic [31:0] i_old,
  output logic [31:0] o_wdata,
  output logic        o_we
);

  logic [31:0] w_operand;

  assign w_operand = i_funct3[2] ? {27'b0, i_rs1_idx} : i_rs1_val;

  always_comb begin
    o_wdata = w_operand;
    case (csr_op_t'(i_funct3))
      CSR_OP_RW, CSR_OP_RWI: o_wdata = w_operand;
      CSR_OP_RS, CSR_OP_RSI: o_wdata = i_old | w_operand;
      CSR_OP_RC, CSR_OP_RCI: o_wdata = i_old & ~w_operand;
      default:               o_wdata = w_operand;
    endcase
  end

  // Set/clear with x0 (or zimm 0) is a pure read; plain writes always write.
  assign o_we = (i_funct3[1:0] == 2'b01) || (i_rs1_idx != 5'd0);

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - sequences one CSR instruction as read, optional write, response.
import csr_access_unit_pkg::*;

module csr_access_unit #(
  parameter int CHECK_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rd_idx,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic        csr_wr,
  output logic [11:0] csr_address,
  output logic [31:0] csr_wrdata,
  input  logic [31:0] csr_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [31:0] r_rs1_val;
  logic [4:0]  r_rs1_idx;
  logic [4:0]  r_rd_idx;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_op_bad;
  logic        w_ro_write;
  logic        w_addr_bad;
  logic        w_illegal;
  logic        w_unused_ok;

  csr_wdata_gen u_wdata_gen (
    .i_funct3  (r_funct3),
    .i_rs1_val (r_rs1_val),
    .i_rs1_idx (r_rs1_idx),
    .i_old     (r_old),
    .o_wdata   (w_wdata),
    .o_we      (w_we)
  );

  // The destination index travels with the request but the pipeline tracks rd itself.
  assign w_unused_ok = &{1'b0, r_rd_idx};

  assign w_op_bad   = (r_funct3[1:0] == 2'b00);
  assign w_ro_write = w_we && (r_addr[11:10] == 2'b11);
  assign w_addr_bad = (CHECK_ADDR != 0) && !csr_addr_known(r_addr);
  assign w_illegal  = w_op_bad || w_ro_write || w_addr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_funct3  <= 3'd0;
      r_addr    <= 12'd0;
      r_rs1_val <= 32'd0;
      r_rs1_idx <= 5'd0;
      r_rd_idx  <= 5'd0;
      r_old     <= 32'd0;
      r_rdata   <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_funct3  <= funct3;
            r_addr    <= csr_addr;
            r_rs1_val <= rs1_val;
            r_rs1_idx <= rs1_idx;
            r_rd_idx  <= rd_idx;
            r_rdata   <= 32'd0;
            r_illegal <= 1'b0;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          r_old     <= csr_rdata;
          r_illegal <= w_illegal;
          r_rdata   <= w_illegal ? 32'd0 : csr_rdata;
          r_state   <= (w_we && !w_illegal) ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign req_ready    = (r_state == ST_IDLE);
  assign resp_valid   = (r_state == ST_RESP);
  assign resp_rdata   = r_rdata;
  assign resp_illegal = r_illegal;
  assign csr_wr       = (r_state == ST_WRITE);
  assign csr_address  = ((r_state == ST_READ) || (r_state == ST_WRITE)) ? r_addr : 12'h000;
  assign csr_wrdata   = (r_state == ST_WRITE) ? w_wdata : 32'd0;

endmodule
